rf_mp: RTL and testbench

Parametrised multi-port register file for the datapath: the successor to the two-read/one-write register file. Width, depth and read/write port counts are configurable. A sequential clear engine leaves the storage free of a wide single-cycle reset. A per-register busy scoreboard lets the pipeline stall on pending producers, and same-cycle write-to-read forwarding can be compiled in. Register 0 is hard-wired to zero.

---
 rtl/rf_pkg.sv | 10 +
 rtl/rf_wr_select.sv | 27 ++
 rtl/rf_mp.sv | 108 ++++++++++
 tb/tb_rf_mp.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// rf_pkg: shared state encoding, address/enable constants and default parameters for rf_mp
package rf_pkg;
  typedef enum logic {CLEAR, READY} rf_state_e;
  localparam int   RF_ADDR_ZERO     = 0;
  localparam logic RF_WRITE_ENABLED = 1'b1;
  localparam int   RF_DATA_W        = 32;
  localparam int   RF_ADDR_W        = 5;
  localparam int   RF_NRD           = 2;
  localparam int   RF_NWR           = 2;
endpackage

// File: rtl/rf_wr_select.sv
// rf_wr_select: finds the highest-index enabled write port targeting addr_i and returns its data
module rf_wr_select
  import rf_pkg::*;
#(
  parameter int NWR    = RF_NWR,
  parameter int ADDR_W = RF_ADDR_W,
  parameter int DATA_W = RF_DATA_W
) (
  input  logic [NWR-1:0]        wr_en_i,
  input  logic [NWR*ADDR_W-1:0] wr_addr_i,
  input  logic [NWR*DATA_W-1:0] wr_data_i,
  input  logic [ADDR_W-1:0]     addr_i,
  output logic                  hit_o,
  output logic [DATA_W-1:0]     data_o
);
  // later ports overwrite earlier matches, so the highest index wins; address zero never hits
  always_comb begin
    hit_o  = 1'b0;
    data_o = '0;
    for (int p = 0; p < NWR; p++)
      if (wr_en_i[p] == RF_WRITE_ENABLED && wr_addr_i[p*ADDR_W +: ADDR_W] == addr_i &&
          addr_i != ADDR_W'(RF_ADDR_ZERO)) begin
        hit_o  = 1'b1;
        data_o = wr_data_i[p*DATA_W +: DATA_W];
      end
  end
endmodule

// File: rtl/rf_mp.sv
// rf_mp: multi-port register file with sequential clear, busy scoreboard and optional forwarding (RF_BYPASS_EN)
module rf_mp
  import rf_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W,
  parameter int NRD    = RF_NRD,
  parameter int NWR    = RF_NWR
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NRD*ADDR_W-1:0] rd_addr,
  output logic [NRD*DATA_W-1:0] rd_data,
  output logic [NRD-1:0]        rd_busy,
  input  logic [NWR-1:0]        wr_en,
  input  logic [NWR*ADDR_W-1:0] wr_addr,
  input  logic [NWR*DATA_W-1:0] wr_data,
  input  logic                  set_en,
  input  logic [ADDR_W-1:0]     set_addr,
  output logic                  ready
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  rf_state_e             state_q, state_d;
  logic [ADDR_W-1:0]     cnt_q, cnt_d;
  logic [DEPTH-1:0]      busy_q, busy_d;
  logic [DATA_W-1:0]     mem_q [DEPTH];
  logic [NWR-1:0]        wr_hit;
  logic [NWR*DATA_W-1:0] wr_win;
  logic                  set_ok;

  assign ready  = state_q == READY;
  assign set_ok = ready && set_en && set_addr != ADDR_W'(RF_ADDR_ZERO);

  // each port resolves its own address so colliding ports all commit the winner's data
  for (genvar w = 0; w < NWR; w++) begin : g_wsel
    rf_wr_select #(.NWR(NWR), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_wsel (
      .wr_en_i  (wr_en),
      .wr_addr_i(wr_addr),
      .wr_data_i(wr_data),
      .addr_i   (wr_addr[w*ADDR_W +: ADDR_W]),
      .hit_o    (wr_hit[w]),
      .data_o   (wr_win[w*DATA_W +: DATA_W])
    );
  end

  // clear engine walks entries 1..LAST then parks in READY; cnt saturates at LAST
  always_comb begin
    state_d = state_q == CLEAR && cnt_q == LAST ? READY : state_q;
    cnt_d   = state_q == CLEAR && cnt_q != LAST ? cnt_q + 1'b1 : cnt_q;
  end

  // committed writes retire a pending producer; a same-cycle set is applied last so it wins
  always_comb begin
    busy_d = busy_q;
    for (int p = 0; p < NWR; p++)
      if (ready && wr_hit[p]) busy_d[wr_addr[p*ADDR_W +: ADDR_W]] = 1'b0;
    if (set_ok) busy_d[set_addr] = 1'b1;
    busy_d[0] = 1'b0;
  end

  // control state with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CLEAR;
      cnt_q   <= ADDR_W'(1);
      busy_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  // storage has no reset; it is zeroed one entry per cycle by the clear engine
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == CLEAR) mem_q[cnt_q] <= '0;
      else
        for (int p = 0; p < NWR; p++)
          if (wr_hit[p]) mem_q[wr_addr[p*ADDR_W +: ADDR_W]] <= wr_win[p*DATA_W +: DATA_W];
    end
  end

  for (genvar r = 0; r < NRD; r++) begin : g_rd
    logic [ADDR_W-1:0] a;
    logic              fhit;
    logic [DATA_W-1:0] fdata;
    assign a = rd_addr[r*ADDR_W +: ADDR_W];
`ifdef RF_BYPASS_EN
    rf_wr_select #(.NWR(NWR), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_fwd (
      .wr_en_i  (wr_en),
      .wr_addr_i(wr_addr),
      .wr_data_i(wr_data),
      .addr_i   (a),
      .hit_o    (fhit),
      .data_o   (fdata)
    );
`else
    assign fhit  = 1'b0;
    assign fdata = '0;
`endif
    assign rd_data[r*DATA_W +: DATA_W] = !ready || a == ADDR_W'(RF_ADDR_ZERO) ? '0 :
                                         fhit ? fdata : mem_q[a];
    assign rd_busy[r] = ready && (fhit ? set_ok && set_addr == a : busy_q[a]);
  end
endmodule

// File: tb/tb_rf_mp.sv
// tb_rf_mp: table-driven check of rf_mp reads, writes, scoreboard and clear/reset sequencing
module tb_rf_mp;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic [1:0]  wr_en;
  logic [9:0]  wr_addr;
  logic [63:0] wr_data;
  logic        set_en;
  logic [4:0]  set_addr;
  logic        ready;
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  rf_mp dut (
    .clk     (clk),
    .rst     (rst),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .rd_busy (rd_busy),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .set_en  (set_en),
    .set_addr(set_addr),
    .ready   (ready)
  );

  typedef struct {
    logic [1:0]  we;
    logic [4:0]  wa0, wa1;
    logic [31:0] wd0, wd1;
    logic        se;
    logic [4:0]  sa, ra0, ra1;
    logic [31:0] d0, d1;
    logic [1:0]  b;
    logic [31:0] f0, f1;
    logic [1:0]  fb;
  } vec_t;

  vec_t v[18];

  function automatic vec_t mk(logic [1:0] we, logic [4:0] wa0, logic [4:0] wa1, logic [31:0] wd0,
                              logic [31:0] wd1, logic se, logic [4:0] sa, logic [4:0] ra0,
                              logic [4:0] ra1, logic [31:0] d0, logic [31:0] d1, logic [1:0] b,
                              logic [31:0] f0, logic [31:0] f1, logic [1:0] fb);
    vec_t t;
    t.we = we; t.wa0 = wa0; t.wa1 = wa1; t.wd0 = wd0; t.wd1 = wd1; t.se = se; t.sa = sa;
    t.ra0 = ra0; t.ra1 = ra1; t.d0 = d0; t.d1 = d1; t.b = b; t.f0 = f0; t.f1 = f1; t.fb = fb;
    return t;
  endfunction

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  task automatic idle();
    wr_en = '0; wr_addr = '0; wr_data = '0; set_en = 1'b0; set_addr = '0;
  endtask

  task automatic clear_run(input int n);
    for (int i = 1; i <= n; i++) begin
      @(posedge clk);
      #1;
      if (i == 30) idle();
      chk($sformatf("clr_ready_%0d", i), {31'b0, ready}, {31'b0, i == 31});
      if (i < 31) begin
        chk($sformatf("clr_rd0_%0d", i), rd_data[31:0], 32'h0);
        chk($sformatf("clr_rd1_%0d", i), rd_data[63:32], 32'h0);
        chk($sformatf("clr_busy_%0d", i), {30'b0, rd_busy}, 32'h0);
      end
    end
  endtask

  initial begin
    logic [31:0] e0, e1;
    logic [1:0]  eb;
    v[0]  = mk(2'b11, 5, 5, 32'h11, 32'h22, 0, 0, 5, 0, 0, 0, 2'b00, 32'h22, 0, 2'b00);
    v[1]  = mk(2'b00, 0, 0, 0, 0, 0, 0, 5, 0, 32'h22, 0, 2'b00, 32'h22, 0, 2'b00);
    v[2]  = mk(2'b01, 0, 0, 32'hDEAD, 0, 0, 0, 0, 5, 0, 32'h22, 2'b00, 0, 32'h22, 2'b00);
    v[3]  = mk(2'b00, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 2'b00, 0, 0, 2'b00);
    v[4]  = mk(2'b00, 0, 0, 0, 0, 1, 7, 7, 5, 0, 32'h22, 2'b00, 0, 32'h22, 2'b00);
    v[5]  = mk(2'b00, 0, 0, 0, 0, 0, 0, 7, 7, 0, 0, 2'b11, 0, 0, 2'b11);
    v[6]  = mk(2'b00, 0, 0, 0, 0, 0, 0, 7, 0, 0, 0, 2'b01, 0, 0, 2'b01);
    v[7]  = mk(2'b10, 0, 7, 0, 32'h77, 0, 0, 7, 7, 0, 0, 2'b11, 32'h77, 32'h77, 2'b00);
    v[8]  = mk(2'b00, 0, 0, 0, 0, 0, 0, 7, 7, 32'h77, 32'h77, 2'b00, 32'h77, 32'h77, 2'b00);
    v[9]  = mk(2'b01, 9, 0, 32'h99, 0, 1, 9, 9, 7, 0, 32'h77, 2'b00, 32'h99, 32'h77, 2'b01);
    v[10] = mk(2'b00, 0, 0, 0, 0, 0, 0, 9, 9, 32'h99, 32'h99, 2'b11, 32'h99, 32'h99, 2'b11);
    v[11] = mk(2'b01, 3, 0, 32'hCAFE, 0, 0, 0, 3, 3, 0, 0, 2'b00, 32'hCAFE, 32'hCAFE, 2'b00);
    v[12] = mk(2'b00, 0, 0, 0, 0, 0, 0, 3, 3, 32'hCAFE, 32'hCAFE, 2'b00, 32'hCAFE, 32'hCAFE, 2'b00);
    v[13] = mk(2'b11, 12, 13, 32'hAAAA, 32'hBBBB, 0, 0, 12, 13, 0, 0, 2'b00, 32'hAAAA, 32'hBBBB, 2'b00);
    v[14] = mk(2'b00, 0, 0, 0, 0, 0, 0, 12, 13, 32'hAAAA, 32'hBBBB, 2'b00, 32'hAAAA, 32'hBBBB, 2'b00);
    v[15] = mk(2'b01, 12, 12, 32'h1234, 32'h5678, 0, 0, 12, 9, 32'hAAAA, 32'h99, 2'b10, 32'h1234, 32'h99, 2'b10);
    v[16] = mk(2'b00, 0, 0, 0, 0, 0, 0, 12, 9, 32'h1234, 32'h99, 2'b10, 32'h1234, 32'h99, 2'b10);
    v[17] = mk(2'b00, 0, 0, 0, 0, 0, 0, 4, 0, 0, 0, 2'b00, 0, 0, 2'b00);
    idle();
    rd_addr = {5'd5, 5'd4};
    @(posedge clk);
    #1;
    chk("rst_ready", {31'b0, ready}, 32'h0);
    chk("rst_rd0", rd_data[31:0], 32'h0);
    rst     = 1'b0;
    wr_en   = 2'b11;
    wr_addr = {5'd4, 5'd4};
    wr_data = {32'h4444, 32'h4343};
    set_en  = 1'b1;
    set_addr = 5'd4;
    clear_run(31);
    for (int i = 0; i < 18; i++) begin
      @(posedge clk);
      #1;
      wr_en    = v[i].we;
      wr_addr  = {v[i].wa1, v[i].wa0};
      wr_data  = {v[i].wd1, v[i].wd0};
      set_en   = v[i].se;
      set_addr = v[i].sa;
      rd_addr  = {v[i].ra1, v[i].ra0};
`ifdef RF_BYPASS_EN
      e0 = v[i].f0; e1 = v[i].f1; eb = v[i].fb;
`else
      e0 = v[i].d0; e1 = v[i].d1; eb = v[i].b;
`endif
      #4;
      chk($sformatf("vec%0d_rd0", i), rd_data[31:0], e0);
      chk($sformatf("vec%0d_rd1", i), rd_data[63:32], e1);
      chk($sformatf("vec%0d_busy", i), {30'b0, rd_busy}, {30'b0, eb});
    end
    @(posedge clk);
    #1;
    idle();
    rst = 1'b1;
    rd_addr = {5'd9, 5'd12};
    @(posedge clk);
    #1;
    chk("ready_rst_ready", {31'b0, ready}, 32'h0);
    chk("ready_rst_rd0", rd_data[31:0], 32'h0);
    chk("ready_rst_busy", {30'b0, rd_busy}, 32'h0);
    rst = 1'b0;
    clear_run(31);
    chk("recleared_rd12", rd_data[31:0], 32'h0);
    chk("recleared_rd9", rd_data[63:32], 32'h0);
    chk("recleared_busy9", {30'b0, rd_busy}, 32'h0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    clear_run(9);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midclr_rst_ready", {31'b0, ready}, 32'h0);
    rst = 1'b0;
    clear_run(31);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
